// File: rtl/track_render.sv
// Two-stage lane/obstacle pixel renderer: per-frame obstacle snapshot, sync
// alignment and one collision pulse per frame.
module track_render #(
   parameter int NUM_LANES       = 3,
   parameter int NUM_OBSTACLES   = 10,
   parameter int LANE_HEIGHT     = 256,
   parameter int OBSTACLE_WIDTH  = 64,
   parameter int OBSTACLE_MARGIN = 16,
   parameter int INDICATOR_WIDTH = 16,
   parameter int PLAYER_X        = 64,
   parameter int PLAYER_W        = 32,
   parameter int BLINK_FRAMES    = 8,
   localparam int LANE_BITS      = $clog2(NUM_LANES)
) (
   input  logic                               system_clock_in,
   input  logic                               reset_in,
   input  logic [10:0]                        hcount,
   input  logic [9:0]                         vcount,
   input  logic                               hsync,
   input  logic                               vsync,
   input  logic                               blank,
   input  logic [NUM_OBSTACLES-1:0]           obstacle_active_in,
   input  logic [NUM_OBSTACLES*LANE_BITS-1:0] obstacle_lane_in,
   input  logic [NUM_OBSTACLES*11-1:0]        obstacle_position_in,
   input  logic [LANE_BITS-1:0]               lane,
   input  logic                               jump,
   output logic                               hsync_out,
   output logic                               vsync_out,
   output logic                               blank_out,
   output logic [11:0]                        rgb,
   output logic                               collision
);

   localparam int FC_BITS = $clog2(2 * BLINK_FRAMES);
   localparam logic [FC_BITS-1:0] FC_MAX   = FC_BITS'(2 * BLINK_FRAMES - 1);
   localparam logic [FC_BITS-1:0] FC_BLINK = FC_BITS'(BLINK_FRAMES);
   localparam logic [10:0] LANE_H    = 11'(LANE_HEIGHT);
   localparam logic [10:0] TRACK_H   = 11'(NUM_LANES * LANE_HEIGHT);
   localparam logic [10:0] MARGIN_TOP = 11'(OBSTACLE_MARGIN);
   localparam logic [10:0] MARGIN_BOT = 11'(LANE_HEIGHT - OBSTACLE_MARGIN);
   localparam logic [10:0] IND_W     = 11'(INDICATOR_WIDTH);
   localparam logic [10:0] OBS_W     = 11'(OBSTACLE_WIDTH);
   localparam logic [10:0] PLAYER_LO = 11'(PLAYER_X);
   localparam logic [10:0] PLAYER_HI = 11'(PLAYER_X + PLAYER_W);

   function automatic logic [11:0] slot_colour(input int idx);
      case (idx)
         32'sd0:  slot_colour = 12'hF00;
         32'sd1:  slot_colour = 12'h0F0;
         32'sd2:  slot_colour = 12'hFF0;
         default: slot_colour = 12'hFFF;
      endcase
   endfunction

   logic                               vsync_hist_r;
   logic                               frame_edge_s;
   logic [NUM_OBSTACLES-1:0]           snap_active_r;
   logic [NUM_OBSTACLES*LANE_BITS-1:0] snap_lane_r;
   logic [NUM_OBSTACLES*11-1:0]        snap_pos_r;
   logic [FC_BITS-1:0]                 frame_cnt_r;

   logic [10:0]              vc_s, lane_idx_s, offset_s;
   logic                     in_track_s, margin_s, indicator_s, lane_match_s, player_s;
   logic [NUM_OBSTACLES-1:0] hit_s;

   logic                     hsync_d1_r, vsync_d1_r, blank_d1_r;
   logic                     in_track_r, margin_r, indicator_r, lane_match_r, player_r, jump_r;
   logic [LANE_BITS-1:0]     lane_idx_r;
   logic [NUM_OBSTACLES-1:0] hit_r;

   logic [11:0] hit_colour_s, ind_colour_s, rgb_next_s;
   logic        any_hit_s, set_s, sticky_r;

   assign frame_edge_s = vsync_hist_r & ~vsync;

   // Falling-vsync detection, obstacle snapshot and blink frame counter.
   always_ff @(posedge system_clock_in or posedge reset_in) begin
      if (reset_in) begin
         vsync_hist_r  <= 1'b1;
         snap_active_r <= '0;
         snap_lane_r   <= '0;
         snap_pos_r    <= '0;
         frame_cnt_r   <= '0;
      end else begin
         vsync_hist_r <= vsync;
         if (frame_edge_s) begin
            snap_active_r <= obstacle_active_in;
            snap_lane_r   <= obstacle_lane_in;
            snap_pos_r    <= obstacle_position_in;
            frame_cnt_r   <= (frame_cnt_r == FC_MAX) ? '0 : frame_cnt_r + 1'b1;
         end else begin
            frame_cnt_r <= frame_cnt_r;
         end
      end
   end

   // Stage 1 geometry: lane decode, margins and per-slot coverage against the snapshot.
   always_comb begin
      vc_s         = {1'b0, vcount};
      lane_idx_s   = vc_s / LANE_H;
      offset_s     = vc_s - (lane_idx_s * LANE_H);
      in_track_s   = vc_s < TRACK_H;
      margin_s     = (offset_s < MARGIN_TOP) || (offset_s > MARGIN_BOT);
      indicator_s  = hcount < IND_W;
      lane_match_s = lane_idx_s == 11'(lane);
      player_s     = lane_match_s && (hcount >= PLAYER_LO) && (hcount < PLAYER_HI);
      hit_s        = '0;
      // pos < OBS_W guards the pos - OBS_W underflow, so pos 0 draws nothing.
      for (int i = 0; i < NUM_OBSTACLES; i++) begin
         hit_s[i] = snap_active_r[i]
                 && (11'(snap_lane_r[i*LANE_BITS +: LANE_BITS]) == lane_idx_s)
                 && (hcount < snap_pos_r[i*11 +: 11])
                 && ((snap_pos_r[i*11 +: 11] < OBS_W)
                     || (hcount > (snap_pos_r[i*11 +: 11] - OBS_W)));
      end
   end

   // Stage 1 registers plus the sync shift register.
   always_ff @(posedge system_clock_in or posedge reset_in) begin
      if (reset_in) begin
         hsync_d1_r   <= 1'b1;
         vsync_d1_r   <= 1'b1;
         blank_d1_r   <= 1'b1;
         hsync_out    <= 1'b1;
         vsync_out    <= 1'b1;
         blank_out    <= 1'b1;
         in_track_r   <= 1'b0;
         margin_r     <= 1'b0;
         indicator_r  <= 1'b0;
         lane_match_r <= 1'b0;
         player_r     <= 1'b0;
         jump_r       <= 1'b0;
         lane_idx_r   <= '0;
         hit_r        <= '0;
      end else begin
         hsync_d1_r   <= hsync;
         vsync_d1_r   <= vsync;
         blank_d1_r   <= blank;
         hsync_out    <= hsync_d1_r;
         vsync_out    <= vsync_d1_r;
         blank_out    <= blank_d1_r;
         in_track_r   <= in_track_s;
         margin_r     <= margin_s;
         indicator_r  <= indicator_s;
         lane_match_r <= lane_match_s;
         player_r     <= player_s;
         jump_r       <= jump;
         lane_idx_r   <= lane_idx_s[LANE_BITS-1:0];
         hit_r        <= hit_s;
      end
   end

   // Stage 2 colour priority and collision event.
   always_comb begin
      hit_colour_s = 12'hFFF;
      for (int i = NUM_OBSTACLES - 1; i >= 0; i--) begin
         hit_colour_s = hit_r[i] ? slot_colour(i) : hit_colour_s;
      end
      any_hit_s = |hit_r;

      if (!lane_match_r) begin
         ind_colour_s = 12'hFFF;
      end else if (!jump_r) begin
         ind_colour_s = 12'hF00;
      end else if (frame_cnt_r < FC_BLINK) begin
         ind_colour_s = 12'h0F0;
      end else begin
         ind_colour_s = 12'h000;
      end

      if (blank_d1_r) begin
         rgb_next_s = 12'h000;
      end else if (!in_track_r) begin
         rgb_next_s = 12'h000;
      end else if (indicator_r) begin
         rgb_next_s = ind_colour_s;
      end else if (!margin_r && any_hit_s) begin
         rgb_next_s = hit_colour_s;
      end else begin
         rgb_next_s = 12'(lane_idx_r) << 2;
      end

      set_s = !blank_d1_r && in_track_r && !margin_r && any_hit_s && player_r && !jump_r;
   end

   // Output pixel register and sticky collision; a same-cycle set beats the frame clear.
   always_ff @(posedge system_clock_in or posedge reset_in) begin
      if (reset_in) begin
         rgb       <= 12'h000;
         sticky_r  <= 1'b0;
         collision <= 1'b0;
      end else begin
         rgb       <= rgb_next_s;
         collision <= frame_edge_s ? sticky_r : 1'b0;
         if (set_s) begin
            sticky_r <= 1'b1;
         end else if (frame_edge_s) begin
            sticky_r <= 1'b0;
         end else begin
            sticky_r <= sticky_r;
         end
      end
   end

endmodule

// File: doc/track_render.md
Name: track_render

Overview:
- Parametrised, pipelined successor of the lane/obstacle pixel renderer.
- Converts the pixel counters plus the obstacle table into 12-bit RGB, with NUM_LANES lanes and NUM_OBSTACLES obstacles.
- Latches the obstacle table once per frame so the picture cannot tear, and aligns the sync outputs to the pixel pipeline.
- Detects player/obstacle pixel overlap and reports one collision pulse per frame to the game FSM.

Parameters:
- NUM_LANES, 3, number of horizontal lanes; LANE_BITS = $clog2(NUM_LANES).
- NUM_OBSTACLES, 10, obstacle slots.
- LANE_HEIGHT, 256, lines per lane.
- OBSTACLE_WIDTH, 64, obstacle width in pixels.
- OBSTACLE_MARGIN, 16, blank lines at the top and bottom of each lane.
- INDICATOR_WIDTH, 16, lane indicator column width, hcount < INDICATOR_WIDTH.
- PLAYER_X, 64, first pixel of the player box.
- PLAYER_W, 32, player box width.
- BLINK_FRAMES, 8, frames per blink half-period while jumping.

Ports:
- system_clock_in  in  1  pixel/system clock.
- reset_in  in  1  asynchronous active-high reset.
- hcount  in  11  pixel column.
- vcount  in  10  pixel line.
- hsync  in  1  active-low horizontal sync.
- vsync  in  1  active-low vertical sync.
- blank  in  1  1 = outside the visible area.
- obstacle_active_in  in  NUM_OBSTACLES  per-slot active flag.
- obstacle_lane_in  in  NUM_OBSTACLES*LANE_BITS  slot i at [i*LANE_BITS +: LANE_BITS].
- obstacle_position_in  in  NUM_OBSTACLES*11  right edge of slot i (exclusive), at [i*11 +: 11].
- lane  in  LANE_BITS  player lane.
- jump  in  1  player airborne.
- hsync_out  out  1  hsync delayed 2 cycles.
- vsync_out  out  1  vsync delayed 2 cycles.
- blank_out  out  1  blank delayed 2 cycles.
- rgb  out  12  pixel colour, aligned with the *_out syncs.
- collision  out  1  one-cycle pulse at frame boundary.

Behaviour:
- Reset (asynchronous, reset_in=1):
  - rgb=0, collision=0.
  - hsync_out=1, vsync_out=1, blank_out=1.
  - Snapshot cleared (all slots inactive), frame counter=0, sticky hit=0, vsync history=1.
- Frame boundary:
  - Defined as the cycle where registered vsync was 1 and vsync=0.
  - On that cycle:
    - snapshot <= obstacle_* inputs;
    - collision <= sticky hit, and sticky hit <= 0;
    - frame counter increments, wrapping at 2*BLINK_FRAMES-1 → 0.
  - collision is 0 on all other cycles.
  - Rendering uses only the snapshot, never the live inputs.
  - lane and jump are sampled live.
- Stage 1 (registered), computes:
  - lane index L = vcount / LANE_HEIGHT, and in_track = (vcount < NUM_LANES*LANE_HEIGHT);
  - offset o = vcount − L*LANE_HEIGHT, and margin = (o < OBSTACLE_MARGIN) || (o > LANE_HEIGHT − OBSTACLE_MARGIN);
  - indicator = hcount < INDICATOR_WIDTH;
  - per-slot hit[i] = active[i] && lane[i]==L && hcount < pos[i] && (pos[i] < OBSTACLE_WIDTH || hcount > pos[i] − OBSTACLE_WIDTH);
  - player = (L==lane) && PLAYER_X ≤ hcount < PLAYER_X+PLAYER_W.
  - All compares are unsigned 11-bit. The pos<WIDTH term prevents underflow, so an obstacle at position 0 draws nothing.
- Stage 2 (registered output), rgb priority:
  1. blank → 0.
  2. !in_track → 0.
  3. indicator → player-lane colour if L==lane, else FFF. Player-lane colour:
     - no jump: F00;
     - jump and frame counter < BLINK_FRAMES: 0F0;
     - jump and frame counter ≥ BLINK_FRAMES: 000.
  4. !margin and any hit → colour of the lowest-index hit slot: 0 → F00, 1 → 0F0, 2 → FF0, others → FFF.
  5. Otherwise background {10'b0, L} << 2.
- Sticky hit:
  - Set on a stage-2 cycle where !blank && in_track && !margin && any hit && player && !jump.
  - If a frame boundary coincides with a set event, the set wins: sticky=1 and collision reports the old value.
- Latency:
  - Exactly 2 cycles from inputs to rgb and *_out.
  - Syncs pass through a 2-deep shift register, independent of the pixel data.
- Reset mid-frame: takes effect immediately; the first snapshot is taken at the next frame boundary.

Test Plan:
- Reset asserted asynchronously mid-line → rgb=000, hsync_out=vsync_out=blank_out=1 on the same cycle without a clock edge. Release reset; the first pixel appears 2 cycles after the first input.
- Slot 0 active, lane 1, pos 300, snapshot taken; scan line 300 → rgb=F00 for hcount 237..299, 004 at 236 and 300; syncs delayed exactly 2 cycles.
- Slots 0 and 3 overlap in lane 0 at line 100 → F00 (slot 0 wins). Line 5 is in the margin → background 000. Line 800 with NUM_LANES=3 → 000.
- Slot 1 at pos 20 → hcount 16..19 drawn 0F0. hcount 0..15 shows the indicator instead. Slot 2 at pos 0 → draws nothing.
- Change obstacle_position_in mid-frame → picture unchanged until after the next vsync falling edge.
- Obstacle overlapping the player box, jump=0 → collision=1 for one cycle at the next frame boundary, 0 otherwise. Same with jump=1 → no pulse, and the indicator alternates 0F0/000 every 8 frames.
